// File: rtl/intctl.sv
// Interrupt controller: IF/IE registers, rising-edge capture of NUM_SRC lines, fixed priority (bit 0 highest).
// Optional macro INTCTL_MISSED_EN adds the dmissed saturating counter of edges lost to an already-set flag.
module intctl #(
   parameter int          NUM_SRC    = 5,
   parameter logic [15:0] IF_ADDR    = 16'hff0f,
   parameter logic [15:0] IE_ADDR    = 16'hffff,
   parameter logic [15:0] VEC_BASE   = 16'h0040,
   parameter int          VEC_STRIDE = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [15:0]        address,
   input  logic [7:0]         indata,
   output logic [7:0]         outdata,
   input  logic               load,
   input  logic               store,
   input  logic [NUM_SRC-1:0] src,
   output logic               intreq,
   output logic [15:0]        intaddress,
   input  logic               intack,
   output logic [NUM_SRC-1:0] dints
`ifdef INTCTL_MISSED_EN
   ,
   output logic [7:0]         dmissed
`endif
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t             state_reg, state_next;
   logic [NUM_SRC-1:0] if_reg, if_next;
   logic [NUM_SRC-1:0] ie_reg, ie_next;
   logic [NUM_SRC-1:0] src_d_reg;
   logic [NUM_SRC-1:0] set, pend, sel, ack_clr;
   logic [2:0]         idx_reg, idx_next, low_idx;
   logic [15:0]        vec_reg, vec_next;
   logic               if_sel, ie_sel, if_wr, ie_wr, ack_fire, cancel;

   // IF decode takes precedence when both registers share an address
   assign if_sel   = (address == IF_ADDR);
   assign ie_sel   = (address == IE_ADDR) && !if_sel;
   assign if_wr    = store && if_sel;
   assign ie_wr    = store && ie_sel;
   assign set      = src & ~src_d_reg;
   assign pend     = if_reg & ie_reg;
   assign ack_fire = (state_reg == REQ) && intack;

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sel
         assign sel[gi] = (idx_reg == 3'(gi));
      end
   endgenerate

   assign ack_clr = ack_fire ? sel : '0;

   // A new edge always survives a same-cycle write or acknowledge clear
   always_comb begin
      if_next = if_wr ? indata[NUM_SRC-1:0] : if_reg;
      if_next = (if_next & ~ack_clr) | set;
      ie_next = ie_wr ? indata[NUM_SRC-1:0] : ie_reg;
   end

   always_comb begin
      low_idx = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pend[i]) low_idx = 3'(i);
      end
   end

   // Request is withdrawn when the latched source stops being pending enabled
   assign cancel = ((if_next & ie_next & sel) == '0);

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      vec_next   = vec_reg;
      case (state_reg)
         IDLE: begin
            if (pend != '0) begin
               state_next = REQ;
               idx_next   = low_idx;
               vec_next   = VEC_BASE + 16'(VEC_STRIDE) * {13'd0, low_idx};
            end
         end
         REQ: begin
            if (ack_fire || cancel) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         if_reg    <= '0;
         ie_reg    <= '0;
         src_d_reg <= '0;
         idx_reg   <= 3'd0;
         vec_reg   <= VEC_BASE;
      end else begin
         state_reg <= state_next;
         if_reg    <= if_next;
         ie_reg    <= ie_next;
         src_d_reg <= src;
         idx_reg   <= idx_next;
         vec_reg   <= vec_next;
      end
   end

   assign intreq     = (state_reg == REQ);
   assign intaddress = vec_reg;
   assign dints      = pend;

   // Unimplemented IF bits read as 1, unimplemented IE bits as 0
   always_comb begin
      outdata = 8'h00;
      if (load && if_sel) begin
         outdata                = 8'hff;
         outdata[NUM_SRC-1:0]   = if_reg;
      end else if (load && ie_sel) begin
         outdata[NUM_SRC-1:0]   = ie_reg;
      end
   end

`ifdef INTCTL_MISSED_EN
   logic [NUM_SRC-1:0] wr_clr, missed;
   logic [3:0]         miss_cnt;
   logic [8:0]         miss_sum;
   logic [7:0]         miss_reg, miss_next;

   assign wr_clr = if_wr ? ~indata[NUM_SRC-1:0] : '0;
   assign missed = set & if_reg & ~(ack_clr | wr_clr);

   always_comb begin
      miss_cnt = 4'd0;
      for (int i = 0; i < NUM_SRC; i++) begin
         miss_cnt = miss_cnt + 4'(missed[i]);
      end
      miss_sum  = {1'b0, miss_reg} + {5'd0, miss_cnt};
      miss_next = miss_sum[8] ? 8'hff : miss_sum[7:0];
      if (if_wr) miss_next = 8'h00;
   end

   always_ff @(posedge clock) begin
      if (reset) miss_reg <= 8'h00;
      else       miss_reg <= miss_next;
   end

   assign dmissed = miss_reg;
`endif

endmodule
